// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: each stage ripples one WIDTH/STAGES
// chunk and registers its carry; valid/ready handshake with a single global stall.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int C = WIDTH / STAGES;

  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             iv;
    logic             ic;
    logic [WIDTH-1:0] ia;
    logic [WIDTH-1:0] ib;
    logic [WIDTH-1:0] isum;
    logic [C-1:0]     ac;
    logic [C-1:0]     bc;
    logic [C:0]       part;
    logic [WIDTH-1:0] ns;

    if (k == 0) begin : g_src
      // Operand B is inverted once on entry; the carry-in supplies the +1.
      assign iv   = in_valid;
      assign ic   = sub;
      assign ia   = a;
      assign ib   = sub ? ~b : b;
      assign isum = '0;
    end else begin : g_link
      assign iv   = g_stage[k-1].g_pipe.rv;
      assign ic   = g_stage[k-1].g_pipe.rc;
      assign ia   = g_stage[k-1].g_pipe.ra;
      assign ib   = g_stage[k-1].g_pipe.rb;
      assign isum = g_stage[k-1].g_pipe.rs;
    end

    assign ac   = C'(ia >> (k * C));
    assign bc   = C'(ib >> (k * C));
    assign part = {1'b0, ac} + {1'b0, bc} + (C + 1)'(ic);

    always_comb begin
      ns           = isum;
      ns[k*C +: C] = part[C-1:0];
    end

    if (k < STAGES - 1) begin : g_pipe
      logic             rv;
      logic             rc;
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic [WIDTH-1:0] rs;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rv <= 1'b0;
        end else if (advance) begin
          rv <= iv;
        end
      end

      always_ff @(posedge clk) begin
        if (advance) begin
          rc <= part[C];
          ra <= ia;
          rb <= ib;
          rs <= ns;
        end
      end
    end else begin : g_out
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          out_valid <= 1'b0;
          sum       <= '0;
          carryout  <= 1'b0;
          overflow  <= 1'b0;
          zero      <= 1'b0;
        end else if (advance) begin
          out_valid <= iv;
          sum       <= ns;
          carryout  <= part[C];
          overflow  <= (ia[WIDTH-1] == ib[WIDTH-1]) && (ns[WIDTH-1] != ia[WIDTH-1]);
          zero      <= (ns == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed checks on an 8-bit/2-stage instance and a
// randomized sweep over STAGES 1/2/4/8 at 32 bits against an arithmetic reference.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;

  // directed instance, WIDTH=8 STAGES=2
  logic       d_iv, d_sub, d_or;
  logic [7:0] d_a, d_b;
  wire        d_ir, d_ov, d_c, d_o, d_z;
  wire  [7:0] d_sum;

  pipelined_addsub #(.WIDTH(8), .STAGES(2)) u_dir (
    .clk(clk), .reset(rst), .in_valid(d_iv), .in_ready(d_ir), .a(d_a), .b(d_b),
    .sub(d_sub), .out_valid(d_ov), .out_ready(d_or), .sum(d_sum), .carryout(d_c),
    .overflow(d_o), .zero(d_z)
  );

  // sweep instances, WIDTH=32, STAGES = 1 << i
  logic [3:0]        sw_iv, sw_sub, sw_or;
  logic [3:0][31:0]  sw_a, sw_b;
  wire  [3:0]        sw_ir, sw_ov, sw_c, sw_o, sw_z;
  wire  [3:0][31:0]  sw_sum;

  for (genvar i = 0; i < 4; i++) begin : g_sw
    pipelined_addsub #(.WIDTH(32), .STAGES(1 << i)) u_sw (
      .clk(clk), .reset(rst), .in_valid(sw_iv[i]), .in_ready(sw_ir[i]), .a(sw_a[i]),
      .b(sw_b[i]), .sub(sw_sub[i]), .out_valid(sw_ov[i]), .out_ready(sw_or[i]),
      .sum(sw_sum[i]), .carryout(sw_c[i]), .overflow(sw_o[i]), .zero(sw_z[i])
    );
  end

  logic [34:0] expq [4][$];

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic, packed {carry, ovf, zero, sum}.
  function automatic logic [34:0] model(input logic [31:0] aa, input logic [31:0] bb,
                                        input logic s);
    longint m    = 64'sd1 <<< 32;
    longint half = m / 2;
    longint ua   = longint'({32'd0, aa});
    longint ub   = longint'({32'd0, bb});
    longint full, sa, sb, sr;
    logic   c, ov;
    logic [31:0] r;
    full = s ? (ua - ub + m) : (ua + ub);
    c    = (full >= m);
    r    = 32'(full % m);
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    sr   = s ? (sa - sb) : (sa + sb);
    ov   = (sr < -half) || (sr >= half);
    return {c, ov, (r == 32'd0), r};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic d_single(input string tag, input logic [7:0] aa, input logic [7:0] bb,
                          input logic ss, input logic [10:0] exp);
    @(posedge clk); #1;
    d_iv = 1'b1; d_a = aa; d_b = bb; d_sub = ss;
    @(posedge clk); #1;
    d_iv = 1'b0;
    @(negedge clk);
    check({tag, "_lat1"}, d_ov, 1'b0);
    @(negedge clk);
    check({tag, "_valid"}, d_ov, 1'b1);
    check({tag, "_res"}, {d_c, d_o, d_z, d_sum}, exp);
  endtask

  initial begin
    logic [3:0] acc;
    int         lat [4];
    int         issued [4];
    int         cyc;
    logic [34:0] e;

    rst = 1'b1;
    d_iv = 1'b0; d_a = '0; d_b = '0; d_sub = 1'b0; d_or = 1'b1;
    sw_iv = '0; sw_a = '0; sw_b = '0; sw_sub = '0; sw_or = '1;
    acc = '0;
    #12;
    check("rst_out", {d_ov, d_c, d_o, d_z, d_sum}, 12'h000);
    check("rst_in_ready", d_ir, 1'b1);
    check("rst_sw_valid", sw_ov, 4'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    d_single("ff_p_01", 8'hFF, 8'h01, 1'b0, {1'b1, 1'b0, 1'b1, 8'h00});
    d_single("7f_p_01", 8'h7F, 8'h01, 1'b0, {1'b0, 1'b1, 1'b0, 8'h80});
    d_single("05_m_07", 8'h05, 8'h07, 1'b1, {1'b0, 1'b0, 1'b0, 8'hFE});
    d_single("80_m_01", 8'h80, 8'h01, 1'b1, {1'b1, 1'b1, 1'b0, 8'h7F});
    d_single("00_m_00", 8'h00, 8'h00, 1'b1, {1'b1, 1'b0, 1'b1, 8'h00});

    // back-to-back, no stall
    @(posedge clk); #1;
    d_iv = 1'b1; d_a = 8'h10; d_b = 8'h01; d_sub = 1'b0;
    @(posedge clk); #1;
    d_a = 8'h20; d_b = 8'h02;
    @(negedge clk); check("b2b_c1_valid", d_ov, 1'b0);
    @(posedge clk); #1;
    d_a = 8'h30; d_b = 8'h03;
    @(negedge clk); check("b2b_c2", {d_ov, d_sum}, 9'h111);
    @(posedge clk); #1;
    d_iv = 1'b0;
    @(negedge clk); check("b2b_c3", {d_ov, d_sum}, 9'h122);
    @(negedge clk); check("b2b_c4", {d_ov, d_sum}, 9'h133);
    @(negedge clk); check("b2b_c5_valid", d_ov, 1'b0);

    // same ops, output stalled three cycles once the first result appears
    @(posedge clk); #1;
    d_iv = 1'b1; d_a = 8'h10; d_b = 8'h01;
    @(posedge clk); #1;
    d_a = 8'h20; d_b = 8'h02;
    @(negedge clk); check("stl_c1_valid", d_ov, 1'b0);
    @(posedge clk); #1;
    d_a = 8'h30; d_b = 8'h03; d_or = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stl_hold%0d", i), {d_ir, d_ov, d_c, d_o, d_z, d_sum}, 13'h0811);
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    d_or = 1'b1;
    @(negedge clk); check("stl_c5", {d_ir, d_ov, d_sum}, 10'h311);
    @(posedge clk); #1;
    d_iv = 1'b0;
    @(negedge clk); check("stl_c6", {d_ov, d_sum}, 9'h122);
    @(negedge clk); check("stl_c7", {d_ov, d_sum}, 9'h133);
    @(negedge clk); check("stl_c8_valid", d_ov, 1'b0);

    // asynchronous reset with two ops in flight
    @(posedge clk); #1;
    d_iv = 1'b1; d_a = 8'hFF; d_b = 8'h01;
    @(posedge clk); #1;
    d_a = 8'h7F; d_b = 8'h01;
    @(posedge clk); #1;
    d_iv = 1'b0;
    @(negedge clk); check("ars_pre", {d_ov, d_c, d_o, d_z, d_sum}, 12'hD00);
    #2 rst = 1'b1;
    #1 check("ars_drop", {d_ov, d_c, d_o, d_z, d_sum}, 12'h000);
    check("ars_in_ready", d_ir, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("ars_stale%0d", i), d_ov, 1'b0);
    end

    // latency of each sweep instance with no stall
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      sw_a[i] = $urandom; sw_b[i] = $urandom; sw_sub[i] = 1'($urandom_range(0, 1));
      lat[i] = 0;
    end
    sw_iv = '1;
    @(posedge clk); #1;
    sw_iv = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (lat[i] == 0 && sw_ov[i]) lat[i] = c;
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("sw%0d_latency", i), lat[i], 1 << i);

    // randomized traffic with random stalls
    for (int i = 0; i < 4; i++) issued[i] = 0;
    cyc = 0;
    while ((issued[0] < 10000 || issued[1] < 10000 || issued[2] < 10000 ||
            issued[3] < 10000) && cyc < 40000) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (!(sw_iv[i] && !acc[i])) begin
          sw_iv[i]  = (issued[i] < 10000) && ($urandom_range(0, 3) != 0);
          sw_a[i]   = pick();
          sw_b[i]   = pick();
          sw_sub[i] = 1'($urandom_range(0, 1));
        end
        sw_or[i] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (sw_ov[i] && sw_or[i]) begin
          check($sformatf("sw%0d_pending", i), (expq[i].size() != 0), 1'b1);
          if (expq[i].size() != 0) begin
            e = expq[i].pop_front();
            check($sformatf("sw%0d_res", i), {sw_c[i], sw_o[i], sw_z[i], sw_sum[i]}, e);
          end
        end
        acc[i] = sw_iv[i] && sw_ir[i];
        if (acc[i]) begin
          expq[i].push_back(model(sw_a[i], sw_b[i], sw_sub[i]));
          issued[i]++;
        end
      end
      cyc++;
    end
    check("sw_cycle_budget", (cyc < 40000), 1'b1);

    @(posedge clk); #1;
    sw_iv = '0; sw_or = '1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (sw_ov[i]) begin
          check($sformatf("sw%0d_drain_pending", i), (expq[i].size() != 0), 1'b1);
          if (expq[i].size() != 0) begin
            e = expq[i].pop_front();
            check($sformatf("sw%0d_drain_res", i), {sw_c[i], sw_o[i], sw_z[i], sw_sum[i]}, e);
          end
        end
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("sw%0d_leftover", i), expq[i].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised, pipelined two's-complement adder/subtractor. It is the multi-bit, registered successor to the team's single-bit full adder. Operands are split into STAGES equal chunks. Each pipeline stage ripples one chunk and registers its carry into the next stage. Input and output use valid/ready handshakes, so the block can sit between datapath registers in the ALU and accept one operation per cycle at full throughput.

Parameters:
WIDTH, 32, operand/result width in bits
STAGES, 4, number of pipeline stages; legal range 1..WIDTH; WIDTH % STAGES == 0 required; chunk size C = WIDTH/STAGES

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operation presented on a/b/sub
in_ready  output  1  block accepts the operation this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  0: a+b; 1: a-b
out_valid  output  1  result fields valid
out_ready  input  1  downstream accepts the result
sum  output  WIDTH  result, modulo 2^WIDTH
carryout  output  1  carry out of the MSB; for subtract, 1 = no borrow
overflow  output  1  signed overflow
zero  output  1  sum == 0

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all stage-valid bits cleared; out_valid=0, sum=0, carryout=0, overflow=0, zero=0. in_ready follows its combinational equation, so it is 1 while out_valid=0.
- Arithmetic:
  - sub=1 computes a + ~b + 1; stage 0 carry-in = sub.
  - overflow = (A_msb == B'_msb) && (sum_msb != A_msb), where B' = sub ? ~b : b.
  - zero is computed from the full WIDTH-bit sum in the final stage.
- Pipeline structure:
  - Stage k (0..STAGES-1) adds chunk k, bits [k*C +: C], with the registered carry from stage k-1.
  - Operand chunks not yet consumed travel with the operation (skew registers).
  - Completed sum chunks are carried forward (de-skew registers), so sum leaves the block aligned.
- Latency: exactly STAGES cycles from handshake (in_valid && in_ready) to out_valid, when there is no stall. STAGES=1 gives one registered stage.
- Global stall: advance = !out_valid || out_ready; in_ready = advance.
  - When advance=0, every stage register holds, including valid bits and carries.
  - When advance=1, all stages shift one step. Stage 0 loads the new operation if in_valid, otherwise a bubble (valid=0).
  - Bubbles are not collapsed. Throughput is 1 op/cycle while out_ready=1.
- Output stability: while out_valid && !out_ready, sum/carryout/overflow/zero are held unchanged.
- Data on ports with an invalid qualifier is don't-care. Internal data registers need not reset; only the valid bits and the output registers are reset.
- Input handshake: in_valid asserted with in_ready=0 is not consumed. The source must hold its operation.
- Simultaneous events: an output handshake and an input handshake in the same cycle are both legal. The retired result leaves, and the new op enters stage 0.
- Reset mid-operation: all in-flight operations are discarded. No out_valid is produced for them after reset deasserts.
- No combinational path from a/b/sub to any output. The only combinational path is out_ready -> in_ready.

Test Plan:
- WIDTH=8, STAGES=2, out_ready=1: a=0xFF, b=0x01, sub=0 -> after 2 cycles sum=0x00, carryout=1, overflow=0, zero=1.
- a=0x7F, b=0x01, sub=0 -> sum=0x80, carryout=0, overflow=1, zero=0. Then a=0x05, b=0x07, sub=1 -> sum=0xFE, carryout=0, overflow=0. Then a=0x80, b=0x01, sub=1 -> sum=0x7F, carryout=1, overflow=1.
- Back-to-back ops 0x10+0x01, 0x20+0x02, 0x30+0x03 on consecutive cycles with out_ready=1 -> out_valid on cycles 2, 3, 4 with sums 0x11, 0x22, 0x33 in order.
- Same three ops, out_ready=0 for 3 cycles once the first result appears -> in_ready=0 during the stall, 0x11 held stable, then 0x11, 0x22, 0x33 delivered in order with nothing lost or duplicated.
- Assert reset asynchronously (mid-cycle) while 2 ops are in flight -> out_valid and the flags drop immediately, and no stale result appears after release.
- Parameter sweep STAGES in {1, 2, 4, 8} at WIDTH=32: 10k random ops with random in_valid/out_ready -> every result matches a+b or a-b mod 2^32 with correct flags, and latency equals STAGES when unstalled.
